// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: default frame width, FSM states, SPI mode codes.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  // Mode code is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser for an async pin with one-cycle rise/fall pulses; pulse appears STAGES cycles
// after the pin changes, no backpressure.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= {STAGES{RST_VAL}};
      sync_d <= RST_VAL;
    end else begin
      sync   <= {sync[STAGES-2:0], din};
      sync_d <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~sync_d;
  assign fall = ~sync[STAGES-1] & sync_d;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI responder shifter in the PCLK domain, modes 0-3, MSB/LSB first; pin-to-action SYNC_STAGES+1 cycles.
// TX: 1-entry buffer (valid/ready), RX: level-valid holding register; SPI_SLV_OVR_EN adds sticky overrun.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              spi_en_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              sclk_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o
`ifdef SPI_SLV_OVR_EN
  ,
  output logic              ovr_o,
  input  logic              ovr_clr_i
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_t        state;
  logic              cpol_q, cpha_q, lsbfe_q;
  logic [DATA_W-1:0] sreg, tx_buf, load_word, rx_shift;
  logic [CNT_W-1:0]  cnt;
  logic              tx_full;
  logic              sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              start, stop, word_done, reload, tx_accept, tx_consume, head;
  logic [SYNC_STAGES-1:0] mosi_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(PCLK), .rst_n(PRESET_n), .din(sclk_i), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(PCLK), .rst_n(PRESET_n), .din(ss_i), .rise(ss_rise), .fall(ss_fall)
  );

  // Same depth as the sclk path so the sampled bit lines up with its edge pulse
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) mosi_sync <= '0;
    else           mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign start      = ss_fall & spi_en_i;
  assign stop       = ss_rise | ~spi_en_i;
  assign word_done  = (state == ST_ACTIVE) & ~stop & sample_edge & (cnt == LAST_BIT);
  assign reload     = ((state == ST_IDLE) & start) | word_done;
  assign tx_accept  = tx_valid_i & tx_ready_o;
  assign tx_consume = reload & tx_full;
  assign load_word  = tx_full ? tx_buf : '0;

  // Sampling advances the register, so the outgoing head is always the next bit to present
  assign rx_shift = lsbfe_q ? {mosi_s, sreg[DATA_W-1:1]} : {sreg[DATA_W-2:0], mosi_s};
  assign head     = lsbfe_q ? sreg[0] : sreg[DATA_W-1];

  assign tx_ready_o = ~tx_full;
  assign busy_o     = (state == ST_ACTIVE);
  assign miso_oe_o  = (state == ST_ACTIVE);

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state      <= ST_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsbfe_q    <= 1'b0;
      sreg       <= '0;
      cnt        <= '0;
      miso_o     <= 1'b0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
`ifdef SPI_SLV_OVR_EN
      ovr_o      <= 1'b0;
`endif
    end else begin
      if (tx_accept) tx_buf <= tx_data_i;
      tx_full <= (tx_full & ~tx_consume) | tx_accept;
      if (rx_ready_i) rx_valid_o <= 1'b0;
`ifdef SPI_SLV_OVR_EN
      if (ovr_clr_i) ovr_o <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cpol_q  <= cpol_i;
          cpha_q  <= cpha_i;
          lsbfe_q <= lsbfe_i;
          cnt     <= '0;
          miso_o  <= 1'b0;
          if (start) begin
            state  <= ST_ACTIVE;
            sreg   <= load_word;
            miso_o <= cpha_i ? 1'b0 : (lsbfe_i ? load_word[0] : load_word[DATA_W-1]);
          end
        end
        ST_ACTIVE: begin
          if (stop) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            miso_o <= 1'b0;
          end else if (sample_edge) begin
            if (word_done) begin
              cnt  <= '0;
              sreg <= load_word;
`ifdef SPI_SLV_OVR_EN
              if (rx_valid_o && !rx_ready_i) begin
                ovr_o <= 1'b1;
              end else begin
                rx_data_o  <= rx_shift;
                rx_valid_o <= 1'b1;
              end
`else
              rx_data_o  <= rx_shift;
              rx_valid_o <= 1'b1;
`endif
            end else begin
              cnt  <= cnt + 1'b1;
              sreg <= rx_shift;
            end
          end else if (shift_edge) begin
            miso_o <= head;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: table of single frames plus hand sequences for multi-frame corners.
module tb_spi_slave_shifter;

  localparam int H = 8;  // PCLK cycles per SCLK half period

  logic       PCLK;
  logic       PRESET_n;
  logic       spi_en_i, cpol_i, cpha_i, lsbfe_i;
  logic       sclk_i, ss_i, mosi_i;
  logic       miso_o, miso_oe_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i, tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_ready_i, busy_o;
`ifdef SPI_SLV_OVR_EN
  logic       ovr_o, ovr_clr_i;
`endif

  spi_slave_shifter dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .spi_en_i(spi_en_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
    .sclk_i(sclk_i), .ss_i(ss_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o)
`ifdef SPI_SLV_OVR_EN
    , .ovr_o(ovr_o), .ovr_clr_i(ovr_clr_i)
`endif
  );

  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic       tx_present;
    logic       push_rx;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  bit         auto_read = 1'b0;
  bit         drain = 1'b0;
  logic       miso_q[$];
  logic [7:0] rx_q[$];
  vec_t       vecs[6];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // bit i of the result is the i-th bit on the wire
  function automatic logic [7:0] ser(input logic [7:0] w, input logic lsb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = lsb ? w[i] : w[7-i];
    return r;
  endfunction

  task automatic offer_tx(input logic [7:0] w);
    int n;
    n = 0;
    tx_data_i  = w;
    tx_valid_i = 1'b1;
    while (!tx_ready_o && n < 200) begin
      wait_cyc(1);
      n++;
    end
    chk("tx_accept_in_time", (n < 200), 1);
    wait_cyc(1);
    tx_valid_i = 1'b0;
  endtask

  task automatic push_miso(input logic [7:0] w, input logic lsb, input int nbits);
    logic [7:0] b;
    b = ser(w, lsb);
    for (int i = 0; i < nbits; i++) miso_q.push_back(b[i]);
  endtask

  task automatic sample_miso();
    logic e;
    if (miso_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL miso_no_expected actual=%0b required=none", miso_o);
    end else begin
      e = miso_q.pop_front();
      chk("miso_bit", miso_o, e);
    end
  endtask

  task automatic xfer(input logic cpol, input logic cpha, input logic [31:0] mosi_bits,
                      input int nbits, input logic raise_ss);
    ss_i = 1'b0;
    if (!cpha) mosi_i = mosi_bits[0];
    wait_cyc(H);
    chk("busy_in_frame", busy_o, 1);
    chk("miso_oe_in_frame", miso_oe_o, 1);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sample_miso();
        sclk_i = ~cpol;
        wait_cyc(H);
        sclk_i = cpol;
        if (i + 1 < nbits) mosi_i = mosi_bits[i+1];
        wait_cyc(H);
      end else begin
        sclk_i = ~cpol;
        mosi_i = mosi_bits[i];
        wait_cyc(H);
        sample_miso();
        sclk_i = cpol;
        wait_cyc(H);
      end
    end
    if (raise_ss) begin
      ss_i = 1'b1;
      wait_cyc(H);
      chk("busy_after_frame", busy_o, 0);
      chk("miso_oe_after_frame", miso_oe_o, 0);
      chk("miso_idle_after_frame", miso_o, 0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] m;
    cpol_i  = v.cpol;
    cpha_i  = v.cpha;
    lsbfe_i = v.lsbfe;
    sclk_i  = v.cpol;
    wait_cyc(10);
    if (v.tx_present) offer_tx(v.tx);
    push_miso(v.exp_miso, v.lsbfe, 8);
    if (v.push_rx) rx_q.push_back(v.exp_rx);
    m = ser(v.mosi, v.lsbfe);
    xfer(v.cpol, v.cpha, {24'h0, m}, 8, 1'b1);
  endtask

  // RX consumer: acknowledges and scores words while auto_read, or just acknowledges while drain
  initial begin
    logic [7:0] e;
    rx_ready_i = 1'b0;
    forever begin
      @(negedge PCLK);
      if (rx_valid_o && !rx_ready_i && (auto_read || drain)) begin
        if (!drain) begin
          if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected_word actual=%0h required=none", rx_data_o);
          end else begin
            e = rx_q.pop_front();
            chk("rx_word", rx_data_o, e);
          end
        end
        rx_ready_i = 1'b1;
      end else begin
        rx_ready_i = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m1, m2;
    int n;
    //          cpol cpha lsb  txp  rx   tx     mosi   exp_miso exp_rx
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hE7, 8'h18, 8'hE7, 8'h18};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h96, 8'h00, 8'h96};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80};

    PRESET_n   = 1'b0;
    spi_en_i   = 1'b0;
    cpol_i     = 1'b0;
    cpha_i     = 1'b0;
    lsbfe_i    = 1'b0;
    sclk_i     = 1'b0;
    ss_i       = 1'b1;
    mosi_i     = 1'b0;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;
`ifdef SPI_SLV_OVR_EN
    ovr_clr_i  = 1'b0;
`endif
    wait_cyc(3);
    chk("rst_miso", miso_o, 0);
    chk("rst_miso_oe", miso_oe_o, 0);
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_busy", busy_o, 0);
`ifdef SPI_SLV_OVR_EN
    chk("rst_ovr", ovr_o, 0);
`endif
    PRESET_n = 1'b1;
    wait_cyc(5);
    spi_en_i  = 1'b1;
    auto_read = 1'b1;

    for (int k = 0; k < 6; k++) run_frame(vecs[k]);

    // Back-to-back frames under one SS low, second TX word offered mid-frame
    cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0; sclk_i = 1'b0;
    wait_cyc(10);
    offer_tx(8'h11);
    push_miso(8'h11, 1'b0, 8);
    push_miso(8'h22, 1'b0, 8);
    rx_q.push_back(8'h5E);
    rx_q.push_back(8'h6B);
    m1 = ser(8'h5E, 1'b0);
    m2 = ser(8'h6B, 1'b0);
    fork
      xfer(1'b0, 1'b0, {16'h0, m2, m1}, 16, 1'b1);
      begin
        n = 0;
        while (!busy_o && n < 100) begin wait_cyc(1); n++; end
        chk("busy_seen_for_refill", busy_o, 1);
        offer_tx(8'h22);
      end
    join
    chk("tx_ready_after_two_words", tx_ready_o, 1);

    // SS rises after 3 bits: no word, loaded TX word dropped, next frame restarts at bit 0
    wait_cyc(10);
    offer_tx(8'h44);
    push_miso(8'h44, 1'b0, 3);
    xfer(1'b0, 1'b0, 32'h0000_0005, 3, 1'b1);
    wait_cyc(10);
    chk("partial_rx_valid", rx_valid_o, 0);
    chk("partial_busy", busy_o, 0);
    chk("partial_tx_ready", tx_ready_o, 1);
    run_frame('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 8'h3A, 8'h99, 8'h3A});

    // Disabled block ignores SS but keeps the buffered TX word
    spi_en_i = 1'b0;
    wait_cyc(5);
    offer_tx(8'h77);
    ss_i = 1'b0;
    wait_cyc(20);
    chk("disabled_busy", busy_o, 0);
    chk("disabled_miso_oe", miso_oe_o, 0);
    chk("disabled_tx_kept", tx_ready_o, 0);
    ss_i = 1'b1;
    wait_cyc(20);
    spi_en_i = 1'b1;
    wait_cyc(5);
    run_frame('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 8'h5C, 8'h77, 8'h5C});

    // Two unread words
    auto_read = 1'b0;
    run_frame('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 8'h00, 8'h00});
    run_frame('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h34, 8'h00, 8'h00});
    wait_cyc(10);
    chk("noread_rx_valid", rx_valid_o, 1);
`ifdef SPI_SLV_OVR_EN
    chk("ovr_rx_data_first_kept", rx_data_o, 8'h12);
    chk("ovr_set", ovr_o, 1);
    ovr_clr_i = 1'b1;
    wait_cyc(1);
    ovr_clr_i = 1'b0;
    wait_cyc(1);
    chk("ovr_cleared", ovr_o, 0);
`else
    chk("overwrite_rx_data", rx_data_o, 8'h34);
`endif
    drain = 1'b1;
    wait_cyc(5);
    drain = 1'b0;
    chk("drained_rx_valid", rx_valid_o, 0);
    auto_read = 1'b1;

    n = 0;
    while (rx_q.size() != 0 && n < 500) begin wait_cyc(1); n++; end
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("miso_queue_drained", miso_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
